// File: rtl/eth_pkt_buf_pkg.sv
// Shared types and constants for the Ethernet multi-slot packet ring buffer.
// Contents: write-side FSM state enum, FCS byte count, count-width helper.
// Optional feature macro consumed by users of this package: ETH_PKT_BUF_FCS_STRIP_EN.
package eth_pkt_buf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  localparam int FCS_BYTES = 4;

  // Bits needed to hold a frame count in the range 0..slots inclusive.
  function automatic int cnt_w(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage

// File: rtl/eth_nios_v3_pkt_ring_buf_if.sv
// Bus bundle for the packet ring buffer: MAC byte stream, Avalon-MM slave, head pop strobe.
// Ports: none (signal container); parameters DATA_W (byte lane width), SLOT_AW (slot offset width).
// master = MAC/Nios side driving the buffer, slave = the buffer itself.
interface eth_nios_v3_pkt_ring_buf_if #(
  parameter int DATA_W  = 8,
  parameter int SLOT_AW = 11
) ();

  logic               wr_valid;
  logic [DATA_W-1:0]  wr_data;
  logic               wr_sop;
  logic               wr_eop;
  logic               wr_err;

  logic [SLOT_AW-1:0] av_address;
  logic               av_chipselect;
  logic               av_read;
  logic               av_write;
  logic [DATA_W-1:0]  av_writedata;
  logic [DATA_W-1:0]  av_readdata;

  logic               rd_pop;

  modport master (
    output wr_valid, wr_data, wr_sop, wr_eop, wr_err,
    output av_address, av_chipselect, av_read, av_write, av_writedata,
    output rd_pop,
    input  av_readdata
  );

  modport slave (
    input  wr_valid, wr_data, wr_sop, wr_eop, wr_err,
    input  av_address, av_chipselect, av_read, av_write, av_writedata,
    input  rd_pop,
    output av_readdata
  );

endinterface

// File: rtl/eth_pkt_buf_dpram.sv
// Single-clock true dual-port RAM; port A write-only, port B read/write with registered read.
// Ports: clk, reset_n (clears only the port B output register), a_* write port, b_* read/write port.
// Latency: port B read data valid one cycle after b_re; read-during-write returns the old word.
module eth_pkt_buf_dpram #(
  parameter int DATA_W = 8,
  parameter int AW     = 13
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_we,
  input  logic [AW-1:0]     a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_re,
  input  logic              b_we,
  input  logic [AW-1:0]     b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_wdata;
    if (b_we) mem[b_addr] <= b_wdata;
  end

  // Output register holds its value between reads.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      b_rdata <= '0;
    end else if (b_re) begin
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/eth_nios_v3_pkt_ring_buf.sv
// Multi-slot Ethernet frame ring buffer: MAC stream fills slots, Nios reads/patches/pops the head.
// Ports: clk, reset_n (sync, active-low), bus (stream + Avalon + rd_pop), frames_pending, head_len,
//   head_err, drop_cnt, irq. Optional macro ETH_PKT_BUF_FCS_STRIP_EN removes the 4 FCS bytes from length.
module eth_nios_v3_pkt_ring_buf
  import eth_pkt_buf_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int SLOT_AW   = 11,
  parameter int NUM_SLOTS = 4,
  parameter int DROP_W    = 16
) (
  input  logic                           clk,
  input  logic                           reset_n,
  eth_nios_v3_pkt_ring_buf_if.slave      bus,
  output logic [cnt_w(NUM_SLOTS)-1:0]    frames_pending,
  output logic [SLOT_AW:0]               head_len,
  output logic                           head_err,
  output logic [DROP_W-1:0]              drop_cnt,
  output logic                           irq
);

  localparam int PTR_W  = $clog2(NUM_SLOTS);
  localparam int CNT_W  = cnt_w(NUM_SLOTS);
  localparam int LEN_W  = SLOT_AW + 1;
  localparam int RAM_AW = PTR_W + SLOT_AW;

  wr_state_t          state_q, state_d;
  logic [LEN_W-1:0]   offs_q, offs_d;
  logic [PTR_W-1:0]   head_q, tail_q, head_d, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DROP_W-1:0]  drop_q, drop_d;
  logic [LEN_W-1:0]   head_len_q, nxt_len;
  logic               head_err_q, nxt_err, irq_q;

  logic [LEN_W-1:0]   len_mem [NUM_SLOTS];
  logic               err_mem [NUM_SLOTS];

  logic               full, pop;
  logic               ram_a_we, start, commit_req, len_ok, commit;
  logic [SLOT_AW-1:0] ram_a_offs;
  logic [LEN_W-1:0]   req_len, commit_len;
  logic [1:0]         drop_inc;
  logic [DROP_W:0]    drop_sum;

  assign full = (count_q == CNT_W'(NUM_SLOTS));
  assign pop  = bus.rd_pop && (count_q != '0);

  // Write-side FSM: next state, RAM write strobe, commit request, drop events.
  always_comb begin
    state_d    = state_q;
    offs_d     = offs_q;
    ram_a_we   = 1'b0;
    ram_a_offs = offs_q[SLOT_AW-1:0];
    start      = 1'b0;
    commit_req = 1'b0;
    req_len    = '0;
    drop_inc   = 2'd0;

    if (bus.wr_valid) begin
      unique case (state_q)
        IDLE, DROP: begin
          if (bus.wr_sop) begin
            if (full) begin
              drop_inc = 2'd1;
              state_d  = bus.wr_eop ? IDLE : DROP;
            end else begin
              start = 1'b1;
            end
          end else if (state_q == DROP && bus.wr_eop) begin
            state_d = IDLE;
          end
        end
        FILL: begin
          if (bus.wr_sop) begin
            // Truncated frame: reuse the same slot from offset 0.
            drop_inc = 2'd1;
            start    = 1'b1;
          end else if (offs_q[SLOT_AW]) begin
            // Slot already holds 2^SLOT_AW bytes; this byte does not fit.
            drop_inc = 2'd1;
            state_d  = bus.wr_eop ? IDLE : DROP;
          end else begin
            ram_a_we = 1'b1;
            offs_d   = offs_q + LEN_W'(1);
            if (bus.wr_eop) begin
              commit_req = 1'b1;
              req_len    = offs_q + LEN_W'(1);
              state_d    = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (start) begin
      ram_a_we   = 1'b1;
      ram_a_offs = '0;
      offs_d     = LEN_W'(1);
      state_d    = bus.wr_eop ? IDLE : FILL;
      commit_req = bus.wr_eop;
      req_len    = LEN_W'(1);
    end

`ifdef ETH_PKT_BUF_FCS_STRIP_EN
    len_ok     = (req_len > LEN_W'(FCS_BYTES));
    commit_len = req_len - LEN_W'(FCS_BYTES);
`else
    len_ok     = 1'b1;
    commit_len = req_len;
`endif

    commit = commit_req && len_ok;
    if (commit_req && !len_ok) drop_inc = drop_inc + 2'd1;
  end

  // Pointer/count bookkeeping; head information is precomputed for the registered outputs.
  always_comb begin
    head_d   = head_q + PTR_W'(pop);
    tail_d   = tail_q + PTR_W'(commit);
    count_d  = count_q + CNT_W'(commit) - CNT_W'(pop);
    drop_sum = {1'b0, drop_q} + (DROP_W+1)'(drop_inc);
    drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

    nxt_len = '0;
    nxt_err = 1'b0;
    if (count_d != '0) begin
      // The new head may be the slot being committed this cycle, before len_mem holds it.
      if (commit && head_d == tail_q) begin
        nxt_len = commit_len;
        nxt_err = bus.wr_err;
      end else begin
        nxt_len = len_mem[head_d];
        nxt_err = err_mem[head_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      offs_q     <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      head_len_q <= '0;
      head_err_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      offs_q     <= offs_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      head_len_q <= nxt_len;
      head_err_q <= nxt_err;
      irq_q      <= (count_d != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      len_mem[tail_q] <= commit_len;
      err_mem[tail_q] <= bus.wr_err;
    end
  end

  eth_pkt_buf_dpram #(
    .DATA_W (DATA_W),
    .AW     (RAM_AW)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .a_we    (ram_a_we),
    .a_addr  ({tail_q, ram_a_offs}),
    .a_wdata (bus.wr_data),
    .b_re    (bus.av_chipselect && bus.av_read),
    .b_we    (bus.av_chipselect && bus.av_write && (count_q != '0)),
    .b_addr  ({head_q, bus.av_address}),
    .b_wdata (bus.av_writedata),
    .b_rdata (bus.av_readdata)
  );

  assign frames_pending = count_q;
  assign head_len       = head_len_q;
  assign head_err       = head_err_q;
  assign drop_cnt       = drop_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_eth_nios_v3_pkt_ring_buf.sv
// Directed bench for the packet ring buffer with a queue-based scoreboard.
// Stimulus pushes expected read data / status snapshots; a negedge monitor pops and compares.
module tb_eth_nios_v3_pkt_ring_buf;

`ifdef ETH_PKT_BUF_FCS_STRIP_EN
  localparam int FCS = 4;
`else
  localparam int FCS = 0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  frames_pending;
  logic [11:0] head_len;
  logic        head_err;
  logic [15:0] drop_cnt;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int pend;
    int hlen;
    int herr;
    int drop;
    int irq;
    bit chk_rd;
    int rdata;
  } stat_t;

  int    rd_q[$];
  stat_t stat_q[$];
  logic  rd_flag = 1'b0;
  logic  stat_req = 1'b0;

  eth_nios_v3_pkt_ring_buf_if bus ();

  eth_nios_v3_pkt_ring_buf dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .frames_pending (frames_pending),
    .head_len       (head_len),
    .head_err       (head_err),
    .drop_cnt       (drop_cnt),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Scoreboard monitor.
  always @(posedge clk) rd_flag <= bus.av_chipselect && bus.av_read;

  always @(negedge clk) begin
    if (rd_flag) begin
      if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
      else check("av_readdata", int'(bus.av_readdata), rd_q.pop_front());
    end
    if (stat_req) begin
      if (stat_q.size() == 0) begin
        check("stat_unexpected", 1, 0);
      end else begin
        stat_t e;
        e = stat_q.pop_front();
        check("frames_pending", int'(frames_pending), e.pend);
        check("head_len", int'(head_len), e.hlen);
        check("head_err", int'(head_err), e.herr);
        check("drop_cnt", int'(drop_cnt), e.drop);
        check("irq", int'(irq), e.irq);
        if (e.chk_rd) check("readdata_reset", int'(bus.av_readdata), e.rdata);
      end
    end
  end

  task automatic idle_inputs();
    bus.wr_valid = 0; bus.wr_data = 0; bus.wr_sop = 0; bus.wr_eop = 0; bus.wr_err = 0;
    bus.av_address = 0; bus.av_chipselect = 0; bus.av_read = 0; bus.av_write = 0;
    bus.av_writedata = 0; bus.rd_pop = 0;
  endtask

  task automatic stat(input int pend, input int hlen, input int herr, input int drop,
                      input bit chk_rd = 0, input int rdata = 0);
    stat_t e;
    e.pend = pend; e.hlen = hlen; e.herr = herr; e.drop = drop;
    e.irq = (pend != 0) ? 1 : 0; e.chk_rd = chk_rd; e.rdata = rdata;
    stat_q.push_back(e);
    stat_req = 1;
    @(posedge clk); #1;
    stat_req = 0;
  endtask

  task automatic send_frame(input int len, input logic [7:0] seed, input bit err,
                            input bit do_eop = 1, input bit pop_eop = 0);
    for (int i = 0; i < len; i++) begin
      bus.wr_valid = 1;
      bus.wr_data  = seed + 8'(i);
      bus.wr_sop   = (i == 0);
      bus.wr_eop   = do_eop && (i == len - 1);
      bus.wr_err   = bus.wr_eop ? err : 1'b0;
      bus.rd_pop   = pop_eop && bus.wr_eop;
      @(posedge clk); #1;
    end
    bus.wr_valid = 0; bus.wr_sop = 0; bus.wr_eop = 0; bus.wr_err = 0; bus.rd_pop = 0;
  endtask

  task automatic av_rd(input int addr, input int exp);
    rd_q.push_back(exp);
    bus.av_chipselect = 1; bus.av_read = 1; bus.av_address = 11'(addr);
    @(posedge clk); #1;
    bus.av_chipselect = 0; bus.av_read = 0;
  endtask

  task automatic av_wr(input int addr, input logic [7:0] data);
    bus.av_chipselect = 1; bus.av_write = 1; bus.av_address = 11'(addr); bus.av_writedata = data;
    @(posedge clk); #1;
    bus.av_chipselect = 0; bus.av_write = 0;
  endtask

  task automatic pop();
    bus.rd_pop = 1;
    @(posedge clk); #1;
    bus.rd_pop = 0;
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    // 1: reset state, then one 60-byte frame read back in full.
    stat(0, 0, 0, 0, 1, 0);
    send_frame(60, 8'h10, 0);
    stat(1, 60 - FCS, 0, 0);
    for (int i = 0; i < 60; i++) av_rd(i, (8'h10 + i) & 8'hFF);
    pop();
    stat(0, 0, 0, 0);

    // 2: five frames back-to-back into four slots; the fifth is dropped.
    send_frame(40, 8'h20, 0);
    send_frame(41, 8'h30, 1);
    send_frame(42, 8'h40, 0);
    send_frame(43, 8'h50, 0);
    send_frame(44, 8'h60, 0);
    stat(4, 40 - FCS, 0, 1);
    pop();
    stat(3, 41 - FCS, 1, 1);
    av_rd(0, 8'h30);
    pop(); pop(); pop();
    stat(0, 0, 0, 1);

    // 3: 2049-byte frame overflows its slot; following 64-byte frame commits.
    send_frame(2049, 8'h00, 0);
    stat(0, 0, 0, 2);
    send_frame(64, 8'h50, 0);
    stat(1, 64 - FCS, 0, 2);
    av_rd(63, 8'h8F);

    // 4: eop and pop in the same cycle with two frames pending.
    send_frame(50, 8'h60, 0);
    stat(2, 64 - FCS, 0, 2);
    send_frame(45, 8'h70, 1, 1, 1);
    stat(2, 50 - FCS, 0, 2);
    pop();
    stat(1, 45 - FCS, 1, 2);
    av_rd(0, 8'h70);
    pop();
    stat(0, 0, 0, 2);

    // 5: sop at byte 30 truncates a frame; the restarted 40-byte frame commits; patch a byte.
    send_frame(30, 8'h80, 0, 0);
    send_frame(40, 8'h90, 0);
    stat(1, 40 - FCS, 0, 3);
    av_wr(5, 8'hA5);
    av_rd(5, 8'hA5);
    av_rd(6, 8'h96);
    av_rd(4, 8'h94);

    // 6: reset mid-frame, then pop on empty and a fresh frame.
    pop();
    send_frame(20, 8'hB0, 0, 0);
    reset_n = 0;
    @(posedge clk); #1;
    reset_n = 1;
    stat(0, 0, 0, 0, 1, 0);
    pop();
    stat(0, 0, 0, 0);
    send_frame(33, 8'hC0, 1);
    stat(1, 33 - FCS, 1, 0);
    av_rd(32, 8'hE0);
    av_rd(0, 8'hC0);

    repeat (3) @(posedge clk);
    check("rd_queue_drained", rd_q.size(), 0);
    check("stat_queue_drained", stat_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
